// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy encoding,
// lane/control bit positions and default widths.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned NUM_LANES_DEF = 5;
  localparam int unsigned CTRL_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int unsigned LANE_RS   = 0;
  localparam int unsigned LANE_RT   = 1;
  localparam int unsigned LANE_IMM  = 2;
  localparam int unsigned LANE_INST = 3;
  localparam int unsigned LANE_PC   = 4;

  localparam int unsigned CTRL_REGDST   = 0;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_REGWRITE = 4;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_MEMWRITE = 6;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage's stall/bubble statistics.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and 2-entry skid buffer.
// Optional stall/bubble counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data_i,
  input  logic [CTRL_W-1:0]             in_ctrl_i,
  input  logic                          flush_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NUM_LANES*DATA_W-1:0]   out_data_o,
  output logic [CTRL_W-1:0]             out_ctrl_o,
  output logic [1:0]                    occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]              stall_cnt_o,
  output logic [CNT_W-1:0]              bubble_cnt_o
`endif
);

  localparam int unsigned PAY_W = NUM_LANES * DATA_W;

  occ_e              occ_q, occ_d;
  logic [PAY_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [PAY_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  assign push = in_valid_i & ready_q;
  assign pop  = valid_q & out_ready_i;

  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d       = OCC_ONE;
          main_data_d = in_data_i;
          main_ctrl_d = in_ctrl_i;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          main_data_d = in_data_i;
          main_ctrl_d = in_ctrl_i;
        end else if (push) begin
          occ_d       = OCC_FULL;
          skid_data_d = in_data_i;
          skid_ctrl_d = in_ctrl_i;
        end else if (pop) begin
          occ_d       = OCC_EMPTY;
          main_ctrl_d = '0;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          occ_d       = OCC_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: begin
        occ_d       = OCC_EMPTY;
        main_ctrl_d = '0;
      end
    endcase
    // Flush overrides any push/pop decided above; the offered input is dropped.
    if (flush_i) begin
      occ_d       = OCC_EMPTY;
      main_ctrl_d = '0;
    end
    valid_d = (occ_d != OCC_EMPTY);
    ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q       <= OCC_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign occupancy_o = occ_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (valid_q & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~valid_q & out_ready_i),
    .cnt_o (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; counter checks compiled in only with
// PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned NL = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = DW * NL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occ;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pops     = 0;

  typedef struct packed {
    logic [PW-1:0] d;
    logic [CW-1:0] c;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic        v2 = 1'b0;
  logic        rdy2_in;
  logic        ov2;
  logic [PW-1:0] od2;
  logic [CW-1:0] oc2;
  logic [1:0]  occ2;
  logic [3:0]  stall2, bubble2;
`endif

  pipe_stage_reg #(.DATA_W(DW), .NUM_LANES(NL), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .occupancy_o (occ)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .bubble_cnt_o(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_reg #(.DATA_W(DW), .NUM_LANES(NL), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (v2),
    .in_ready_o  (rdy2_in),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .flush_i     (1'b0),
    .out_valid_o (ov2),
    .out_ready_i (1'b0),
    .out_data_o  (od2),
    .out_ctrl_o  (oc2),
    .occupancy_o (occ2),
    .stall_cnt_o (stall2),
    .bubble_cnt_o(bubble2)
  );
`endif

  function automatic logic [PW-1:0] pay(input int unsigned id);
    logic [PW-1:0] r;
    logic [15:0]   idl;
    r   = '0;
    idl = id[15:0];
    for (int unsigned k = 0; k < NL; k++) begin
      r[k*DW +: DW] = {idl, 8'(k), 8'hA5};
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] ctl(input int unsigned id);
    logic [6:0] lo;
    lo = id[6:0];
    return {1'b1, lo};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int unsigned id);
    in_valid = 1'b1;
    in_data  = pay(id);
    in_ctrl  = ctl(id);
  endtask

  // Monitor: records accepted inputs, pops and compares presented outputs.
  always @(negedge clk) begin
    item_t it;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (!out_valid) chk_n("ctrl_zero_when_invalid", int'(out_ctrl), 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0h expected no item", out_data);
        end else begin
          it = sb.pop_front();
          chk("pop_data", out_data, it.d);
          chk_n("pop_ctrl", int'(out_ctrl), int'(it.c));
          pops++;
        end
      end
      if (in_valid && in_ready) sb.push_back('{in_data, in_ctrl});
    end
  end

  initial begin
    int unsigned pops0;
    int unsigned id;
    bit          acc;
    bit          done;

    step();
    step();
    rst = 1'b0;
    chk_n("rst_valid", int'(out_valid), 0);
    chk_n("rst_ready", int'(in_ready), 1);
    chk_n("rst_occ", int'(occ), 0);
    chk_n("rst_ctrl", int'(out_ctrl), 0);
    chk("rst_data", out_data, '0);

    // Streaming at full throughput
    out_ready = 1'b1;
    pops0 = pops;
    for (int unsigned i = 0; i < 8; i++) begin
      offer(i);
      step();
      chk_n("stream_valid", int'(out_valid), 1);
      chk_n("stream_occ", int'(occ), 1);
    end
    in_valid = 1'b0;
    step();
    chk_n("stream_drain_occ", int'(occ), 0);
    chk_n("stream_pops", pops - pops0, 8);

    // Stall fills the skid, then release in order
    out_ready = 1'b0;
    offer(100);
    step();
    chk_n("stall_occ_a", int'(occ), 1);
    offer(101);
    step();
    chk_n("stall_occ_b", int'(occ), 2);
    chk_n("stall_ready_b", int'(in_ready), 0);
    offer(102);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk_n("stall_hold_occ", int'(occ), 2);
      chk("stall_hold_data", out_data, pay(100));
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int unsigned i = 0; i < 10 && !done; i++) begin
      acc = in_ready;
      step();
      if (acc) begin
        in_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) chk_n("stall_c_accept_timeout", 0, 1);
    step();
    step();
    chk_n("stall_drain_occ", int'(occ), 0);

    // Flush while FULL with an item offered
    out_ready = 1'b0;
    offer(200);
    step();
    offer(201);
    step();
    chk_n("flush_pre_occ", int'(occ), 2);
    offer(202);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_n("flush_occ", int'(occ), 0);
    chk_n("flush_ctrl", int'(out_ctrl), 0);
    chk_n("flush_ready", int'(in_ready), 1);
    chk_n("flush_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    step();
    step();
    chk_n("flush_no_ghost", int'(out_valid), 0);

    // Flush in ONE drops a simultaneous push
    offer(210);
    step();
    offer(211);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_n("flush_one_occ", int'(occ), 0);
    step();
    chk_n("flush_one_valid", int'(out_valid), 0);

    // Random handshake traffic against the scoreboard
    id = 1000;
    for (int unsigned i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = pay(id);
      in_ctrl   = ctl(id);
      id++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk_n("random_drained", sb.size(), 0);
    chk_n("random_occ", int'(occ), 0);

    // Asynchronous reset mid-stream while FULL
    out_ready = 1'b0;
    offer(300);
    step();
    offer(301);
    step();
    in_valid = 1'b0;
    chk_n("midrst_pre_occ", int'(occ), 2);
    #2;
    rst = 1'b1;
    #1;
    chk_n("midrst_valid", int'(out_valid), 0);
    chk_n("midrst_ctrl", int'(out_ctrl), 0);
    chk_n("midrst_occ", int'(occ), 0);
    chk_n("midrst_ready", int'(in_ready), 1);
    step();
    rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    chk_n("perf_rst_stall", int'(stall_cnt), 0);
    chk_n("perf_rst_bubble", int'(bubble_cnt), 0);
    offer(400);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    chk_n("perf_stall3", int'(stall_cnt), 3);
    chk_n("perf_bubble2", int'(bubble_cnt), 2);

    v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int unsigned i = 0; i < 20; i++) step();
    chk_n("perf_sat_stall", int'(stall2), 15);
    chk_n("perf_sat_bubble", int'(bubble2), 0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
